resp_serializer: RTL and testbench
==================================

RESP_SERIALIZER -- requirements
Module: resp_serializer

Interface
REQ-001 Parameter: SOF_BYTE, 8'hA5, start-of-frame marker emitted first in every response frame.
REQ-002 Parameter: FRAME_LEN, 9, bytes per frame; fixed, not user-overridable in practice.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 resp_fifo_valid  input  1  show-ahead response FIFO non-empty; resp_fifo_data valid while high.
REQ-006 resp_fifo_data  input  resp_packet_t  response packet: status[7:0], addr[15:0], data[31:0].
REQ-007 resp_fifo_rd_en  output  1  one-cycle pop strobe to response FIFO.
REQ-008 byte_fifo_full  input  1  TX byte FIFO full (feeds uart_tx).
REQ-009 byte_fifo_wr_en  output  1  byte write strobe to TX byte FIFO.
REQ-010 byte_fifo_wr_data  output  8  byte being written.
REQ-011 busy  output  1  high whenever a frame is in progress.

Function
REQ-012 Frame order SHALL be: SOF_BYTE, status, addr[15:8], addr[7:0], data[31:24], data[23:16], data[15:8], data[7:0], chk.
REQ-013 chk SHALL be the 8-bit XOR of frame bytes 1..7; SOF excluded.
REQ-014 FSM states SHALL be IDLE and SEND; 4-bit byte index idx 0..8 valid in SEND.
REQ-015 IDLE: if resp_fifo_valid, SHALL assert resp_fifo_rd_en for exactly one cycle, latch resp_fifo_data and computed chk that edge, go to SEND with idx=0.
REQ-016 SEND: byte_fifo_wr_en SHALL be combinational = (state==SEND) && !byte_fifo_full; byte_fifo_wr_data = frame byte[idx] from latched registers.
REQ-017 idx SHALL advance only on cycles where byte_fifo_wr_en is high; byte_fifo_full high SHALL stall with idx and data held.
REQ-018 First byte (SOF) SHALL be presentable the cycle after the pop (latency 1 cycle pop-to-SOF when not full).
REQ-019 On accepted write with idx==8: if resp_fifo_valid, SHALL pop and latch next packet same cycle, remain SEND, idx=0 (gapless back-to-back); else return to IDLE.
REQ-020 resp_fifo_rd_en SHALL never assert in SEND except per REQ-019; never assert when resp_fifo_valid low.
REQ-021 byte_fifo_wr_en SHALL never assert while byte_fifo_full is high (no overflow writes).
REQ-022 busy SHALL equal (state==SEND).
REQ-023 Changes on resp_fifo_data after pop SHALL not affect the frame in flight.

Reset
REQ-024 rst low at a clock edge SHALL force state=IDLE, idx=0, latched packet and chk to 0, regardless of mid-frame position; partial frame is abandoned, not completed.
REQ-025 During and immediately after reset: resp_fifo_rd_en=0, byte_fifo_wr_en=0, byte_fifo_wr_data=8'h00, busy=0.
REQ-026 First pop SHALL occur no earlier than the first edge with rst high.

Structure
REQ-027 resp_packet_t (status, addr, data) and RESP_SOF constant SHALL live in cmd_pkg alongside cmd_packet_t.
REQ-028 No sub-module; byte mux and XOR checksum inline.

Verification
REQ-029 Single packet status=01 addr=1234 data=DEADBEEF, full=0 -> bytes A5 01 12 34 DE AD BE EF 05 on 9 consecutive cycles, one rd_en pulse, busy 9 cycles.
REQ-030 Same packet, full held high cycles 3-5 of frame -> no wr_en while full, identical 9-byte sequence, no drop or duplicate.
REQ-031 Two packets queued (second: status=00 addr=0000 data=00000000) -> 18 bytes gapless, second chk 00, rd_en pulses 9 cycles apart.
REQ-032 rst low after 4th byte -> outputs zero next cycle, state IDLE; after release with valid high, fresh frame starts with A5.
REQ-033 resp_fifo_valid low throughout -> rd_en, wr_en, busy stay 0 for 100 cycles.
REQ-034 Random packets with random full, 1000 frames -> scoreboard reconstructs every packet, checksum matches, no wr_en while full.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared command/response types for the host link.
//   cmd_packet_t   : decoded host command (opcode, addr, data)
//   resp_packet_t  : response returned to the host (status, addr, data)
//   RESP_SOF       : start-of-frame marker leading every response frame
//   RESP_FRAME_LEN : bytes per serialized response frame
//   resp_state_t   : resp_serializer FSM states
//   resp_chk       : XOR checksum over the seven payload bytes of a response
package cmd_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] addr;
        logic [31:0] data;
    } cmd_packet_t;

    typedef struct packed {
        logic [7:0]  status;
        logic [15:0] addr;
        logic [31:0] data;
    } resp_packet_t;

    localparam logic [7:0] RESP_SOF       = 8'hA5;
    localparam int         RESP_FRAME_LEN = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } resp_state_t;

    // Checksum covers status, addr and data bytes; the SOF marker is excluded.
    function automatic logic [7:0] resp_chk(input resp_packet_t p);
        return p.status ^ p.addr[15:8] ^ p.addr[7:0] ^
               p.data[31:24] ^ p.data[23:16] ^ p.data[15:8] ^ p.data[7:0];
    endfunction

endpackage

// File: rtl/resp_serializer.sv
// Serializes response packets from a show-ahead FIFO into 9-byte frames
// (SOF, status, addr hi/lo, data MSB..LSB, XOR checksum) for the UART TX
// byte FIFO. Back-to-back packets are sent without a gap.
// Ports:
//   clk               : clock, rising edge
//   rst               : synchronous reset, active low
//   resp_fifo_valid   : response FIFO non-empty, resp_fifo_data valid
//   resp_fifo_data    : response packet at the FIFO head
//   resp_fifo_rd_en   : one-cycle pop strobe to the response FIFO
//   byte_fifo_full    : TX byte FIFO full
//   byte_fifo_wr_en   : byte write strobe to the TX byte FIFO
//   byte_fifo_wr_data : byte being written
//   busy              : a frame is in progress
module resp_serializer
    import cmd_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE  = RESP_SOF,
    parameter int         FRAME_LEN = RESP_FRAME_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         resp_fifo_valid,
    input  resp_packet_t resp_fifo_data,
    output logic         resp_fifo_rd_en,
    input  logic         byte_fifo_full,
    output logic         byte_fifo_wr_en,
    output logic [7:0]   byte_fifo_wr_data,
    output logic         busy
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    resp_state_t  state_reg, state_next;
    logic [3:0]   idx_reg, idx_next;
    resp_packet_t pkt_reg, pkt_next;
    logic [7:0]   chk_reg, chk_next;

    // Frame byte table built from the latched packet, so the head of the
    // response FIFO may change freely while a frame is in flight.
    logic [7:0] frame_bytes [FRAME_LEN];

    assign frame_bytes[0] = SOF_BYTE;
    assign frame_bytes[1] = pkt_reg.status;
    assign frame_bytes[2] = pkt_reg.addr[15:8];
    assign frame_bytes[3] = pkt_reg.addr[7:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_data_bytes
            assign frame_bytes[4 + gi] = pkt_reg.data[31 - 8*gi -: 8];
        end
    endgenerate

    assign frame_bytes[FRAME_LEN - 1] = chk_reg;

    assign busy = (state_reg == ST_SEND);

    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        pkt_next          = pkt_reg;
        chk_next          = chk_reg;
        resp_fifo_rd_en   = 1'b0;
        byte_fifo_wr_en   = 1'b0;
        byte_fifo_wr_data = 8'h00;

        // Strobes are held off while reset is asserted so that no packet is
        // popped (and lost) or byte written during the reset cycle itself.
        if (rst) begin
            case (state_reg)
                ST_IDLE: begin
                    if (resp_fifo_valid) begin
                        resp_fifo_rd_en = 1'b1;
                        pkt_next        = resp_fifo_data;
                        chk_next        = resp_chk(resp_fifo_data);
                        idx_next        = 4'd0;
                        state_next      = ST_SEND;
                    end
                end
                ST_SEND: begin
                    byte_fifo_wr_en   = !byte_fifo_full;
                    byte_fifo_wr_data = frame_bytes[idx_reg];
                    if (byte_fifo_wr_en) begin
                        if (idx_reg == LAST_IDX) begin
                            idx_next = 4'd0;
                            // Chain straight into the next packet if one waits.
                            if (resp_fifo_valid) begin
                                resp_fifo_rd_en = 1'b1;
                                pkt_next        = resp_fifo_data;
                                chk_next        = resp_chk(resp_fifo_data);
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end else begin
                            idx_next = idx_reg + 4'd1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 4'd0;
            pkt_reg   <= '0;
            chk_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            pkt_reg   <= pkt_next;
            chk_reg   <= chk_next;
        end
    end

endmodule

// File: tb/tb_resp_serializer.sv
module tb_resp_serializer;
    import cmd_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         resp_fifo_valid;
    resp_packet_t resp_fifo_data;
    logic         resp_fifo_rd_en;
    logic         byte_fifo_full;
    logic         byte_fifo_wr_en;
    logic [7:0]   byte_fifo_wr_data;
    logic         busy;

    always #5 clk = ~clk;

    resp_serializer dut (
        .clk               (clk),
        .rst               (rst),
        .resp_fifo_valid   (resp_fifo_valid),
        .resp_fifo_data    (resp_fifo_data),
        .resp_fifo_rd_en   (resp_fifo_rd_en),
        .byte_fifo_full    (byte_fifo_full),
        .byte_fifo_wr_en   (byte_fifo_wr_en),
        .byte_fifo_wr_data (byte_fifo_wr_data),
        .busy              (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    resp_packet_t fifo_q[$];
    logic         allow_valid = 1'b1;

    // Sampled outputs of the most recent cycle.
    logic       s_rd, s_wr, s_busy;
    logic [7:0] s_wd;

    typedef struct {
        resp_packet_t pkt;
        logic [19:0]  full_mask;   // bit n = full on cycle n (cycle 0 = pop)
        logic [71:0]  exp_frame;   // byte 0 in the MSBs
        int           exp_busy;
        int           exp_sof_cyc;
    } vec_t;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference frame builder.
    function automatic logic [71:0] frame_of(input resp_packet_t p);
        logic [55:0] payload;
        logic [7:0]  c;
        payload = p;
        c = 8'h00;
        for (int i = 0; i < 7; i++) c = c ^ payload[8*i +: 8];
        return {8'hA5, payload, c};
    endfunction

    task automatic drive_inputs();
        logic [63:0] junk;
        junk = {$urandom(), $urandom()};
        resp_fifo_valid = (fifo_q.size() > 0) && allow_valid;
        resp_fifo_data  = resp_fifo_valid ? fifo_q[0] : resp_packet_t'(junk[55:0]);
    endtask

    // One clock: apply inputs, sample outputs 2 time units after the edge,
    // check the strobe rules, then advance and model the FIFO pop.
    task automatic cycle(input logic full);
        byte_fifo_full = full;
        drive_inputs();
        #1;
        s_rd   = resp_fifo_rd_en;
        s_wr   = byte_fifo_wr_en;
        s_wd   = byte_fifo_wr_data;
        s_busy = busy;
        check("rd_en_without_valid", 72'(s_rd && !resp_fifo_valid), 72'(0));
        check("wr_en_while_full",    72'(s_wr && full),             72'(0));
        @(posedge clk);
        if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
    endtask

    vec_t vecs [6];

    initial begin
        resp_packet_t p0, p1, p2;
        int           nb, rdc, bc, sof, first_wr, last_wr, rd0, rd1, frames, since;
        logic [71:0]  got, got2, e;
        logic [71:0]  exp_q[$];
        logic         seen;

        p0 = '{status: 8'h01, addr: 16'h1234, data: 32'hDEADBEEF};
        p1 = '{status: 8'h00, addr: 16'h0000, data: 32'h00000000};
        p2 = '{status: 8'h80, addr: 16'h00FF, data: 32'h12345678};

        vecs[0] = '{p0, 20'h00000, 72'hA5_01_12_34_DE_AD_BE_EF_05, 9, 1};
        vecs[1] = '{p0, 20'h00038, 72'hA5_01_12_34_DE_AD_BE_EF_05, 12, 1};
        vecs[2] = '{p2, 20'h00000, 72'hA5_80_00_FF_12_34_56_78_77, 9, 1};
        vecs[3] = '{'{8'hFF, 16'hFFFF, 32'hFFFFFFFF}, 20'h00002,
                    72'hA5_FF_FF_FF_FF_FF_FF_FF_FF, 10, 2};
        vecs[4] = '{p1, 20'h00200, 72'hA5_00_00_00_00_00_00_00_00, 10, 1};
        vecs[5] = '{'{8'h5A, 16'hA55A, 32'h0F0FF0F0}, 20'h00301,
                    72'hA5_5A_A5_5A_0F_0F_F0_F0_A5, 11, 1};

        // Reset with a packet waiting: nothing may pop or write.
        rst = 1'b0;
        byte_fifo_full = 1'b0;
        fifo_q.push_back(p0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            check("reset_rd_en",   72'(s_rd),   72'(0));
            check("reset_wr_en",   72'(s_wr),   72'(0));
            check("reset_wr_data", 72'(s_wd),   72'(0));
            check("reset_busy",    72'(s_busy), 72'(0));
        end
        check("reset_no_pop", 72'(fifo_q.size()), 72'(1));
        fifo_q.delete();
        rst = 1'b1;
        $display("reset: done");

        // Empty FIFO for 100 cycles: fully quiet.
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'($urandom_range(0, 1)));
            seen = seen | s_rd | s_wr | s_busy;
        end
        check("idle_quiet", 72'(seen), 72'(0));
        $display("idle: 100 cycles, activity=%0b", seen);

        // Table of single frames with stall patterns.
        foreach (vecs[v]) begin
            fifo_q.push_back(vecs[v].pkt);
            nb = 0; rdc = 0; bc = 0; sof = -1; got = '0;
            for (int c = 0; c < 20; c++) begin
                cycle(vecs[v].full_mask[c]);
                if (s_rd) rdc++;
                if (s_busy) bc++;
                if (s_wr) begin
                    if (nb == 0) sof = c;
                    got = {got[63:0], s_wd};
                    nb++;
                end
            end
            check($sformatf("vec%0d_frame", v),    got,       vecs[v].exp_frame);
            check($sformatf("vec%0d_nbytes", v),   72'(nb),   72'(9));
            check($sformatf("vec%0d_rd_pulses", v),72'(rdc),  72'(1));
            check($sformatf("vec%0d_busy", v),     72'(bc),   72'(vecs[v].exp_busy));
            check($sformatf("vec%0d_sof_cyc", v),  72'(sof),  72'(vecs[v].exp_sof_cyc));
            $display("vec%0d: frame=%h bytes=%0d busy=%0d", v, got, nb, bc);
        end

        // Two queued packets: 18 gapless bytes, pops 9 cycles apart.
        fifo_q.push_back(p0);
        fifo_q.push_back(p1);
        nb = 0; rdc = 0; got = '0; got2 = '0; first_wr = -1; last_wr = -1; rd0 = -1; rd1 = -1;
        for (int c = 0; c < 30; c++) begin
            cycle(1'b0);
            if (s_rd) begin
                if (rdc == 0) rd0 = c; else rd1 = c;
                rdc++;
            end
            if (s_wr) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                if (nb < 9) got = {got[63:0], s_wd};
                else        got2 = {got2[63:0], s_wd};
                nb++;
            end
        end
        check("b2b_frame0",    got,               72'hA5_01_12_34_DE_AD_BE_EF_05);
        check("b2b_frame1",    got2,              72'hA5_00_00_00_00_00_00_00_00);
        check("b2b_nbytes",    72'(nb),           72'(18));
        check("b2b_rd_pulses", 72'(rdc),          72'(2));
        check("b2b_rd_gap",    72'(rd1 - rd0),    72'(9));
        check("b2b_gapless",   72'(last_wr - first_wr), 72'(17));
        $display("b2b: %h %h bytes=%0d rd_gap=%0d", got, got2, nb, rd1 - rd0);

        // Reset after the 4th byte abandons the frame.
        fifo_q.push_back(p0);
        nb = 0;
        for (int c = 0; c < 12 && nb < 4; c++) begin
            cycle(1'b0);
            if (s_wr) nb++;
        end
        check("midrst_reached_4", 72'(nb), 72'(4));
        fifo_q.push_back(p2);
        rst = 1'b0;
        cycle(1'b0);
        cycle(1'b0);
        check("midrst_rd_en",   72'(s_rd),   72'(0));
        check("midrst_wr_en",   72'(s_wr),   72'(0));
        check("midrst_wr_data", 72'(s_wd),   72'(0));
        check("midrst_busy",    72'(s_busy), 72'(0));
        rst = 1'b1;
        nb = 0; rdc = 0; got = '0;
        for (int c = 0; c < 20; c++) begin
            cycle(1'b0);
            if (s_rd) rdc++;
            if (s_wr) begin
                got = {got[63:0], s_wd};
                nb++;
            end
        end
        check("midrst_fresh_frame", got,      72'hA5_80_00_FF_12_34_56_78_77);
        check("midrst_fresh_bytes", 72'(nb),  72'(9));
        check("midrst_fresh_rd",    72'(rdc), 72'(1));
        $display("midrst: fresh frame=%h", got);

        // Random packets, random availability and back-pressure.
        for (int f = 0; f < 1000; f++) begin
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            fifo_q.push_back(resp_packet_t'(r[55:0]));
            e = frame_of(resp_packet_t'(r[55:0]));
            exp_q.push_back(e);
        end
        frames = 0; since = 0; got = '0;
        for (int c = 0; c < 60000 && frames < 1000; c++) begin
            allow_valid = ($urandom_range(0, 3) != 0);
            cycle(1'($urandom_range(0, 2) == 0));
            if (s_wr) begin
                got = {got[63:0], s_wd};
                since++;
                if (since == 9) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    check($sformatf("rand_frame%0d", frames), got, e);
                    $display("rand frame %0d: %h", frames, got);
                    frames++;
                    since = 0;
                end
            end
        end
        allow_valid = 1'b1;
        check("rand_frames_done", 72'(frames), 72'(1000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
